riscv_ex_tag_pipe: RTL and testbench

Parametrised DIFT tag-execution stage that runs alongside the EX stage. It computes multi-bit result tags for multi-operand instructions under a selectable propagation policy and registers them into a one-entry EX/WB tag slot with a valid/ready handshake. It also keeps a sticky PC tag across taken control transfers and raises a stalling, acknowledged trap when a tainted value steers control flow. It extends the single-bit, purely combinational tag path with configurable width, operand count, policy checking, violation counting and back-pressure.

---
 rtl/riscv_tag_pkg.sv | 21 ++
 rtl/riscv_tag_policy.sv | 49 ++++
 rtl/riscv_ex_tag_pipe.sv | 135 +++++++++++++
 tb/tb_riscv_ex_tag_pipe.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_tag_pkg.sv
// Shared types for the DIFT tag-execution slice: propagation policies and the trap FSM.
package riscv_tag_pkg;

    localparam int TAG_MODE_WIDTH = 3;

    typedef enum logic [TAG_MODE_WIDTH-1:0] {
        PASS_A = 3'd0,
        OR_AB  = 3'd1,
        AND_AB = 3'd2,
        OR_ALL = 3'd3,
        PASS_C = 3'd4,
        CLEAR  = 3'd5,
        SET    = 3'd6
    } tag_mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } tag_fsm_e;

endpackage

// File: rtl/riscv_tag_policy.sv
// Combinational tag-propagation policy: selects the result tag from the operand tags
// and reports whether the instruction propagates tags at all.
module riscv_tag_policy
    import riscv_tag_pkg::*;
#(
    parameter int TAG_WIDTH = 1,
    parameter int NUM_OPS   = 3
) (
    input  logic [TAG_MODE_WIDTH-1:0]     mode_i,
    input  logic [NUM_OPS*TAG_WIDTH-1:0]  op_tag_i,
    output logic [TAG_WIDTH-1:0]          result_o,
    output logic                          tag_en_o
);

    logic [TAG_WIDTH-1:0] or_chain [NUM_OPS];
    logic [TAG_WIDTH-1:0] op_a;
    logic [TAG_WIDTH-1:0] op_b;
    logic [TAG_WIDTH-1:0] op_c;
    tag_mode_e            mode;

    assign op_a = op_tag_i[0 +: TAG_WIDTH];
    assign op_b = op_tag_i[TAG_WIDTH +: TAG_WIDTH];
    assign op_c = op_tag_i[(NUM_OPS-1)*TAG_WIDTH +: TAG_WIDTH];
    assign mode = tag_mode_e'(mode_i);

    assign or_chain[0] = op_a;
    generate
        for (genvar gi = 1; gi < NUM_OPS; gi++) begin : g_or_all
            assign or_chain[gi] = or_chain[gi-1] | op_tag_i[gi*TAG_WIDTH +: TAG_WIDTH];
        end
    endgenerate

    // The unassigned code 7 falls through to the CLEAR behaviour, including the enable.
    always_comb begin
        result_o = '0;
        case (mode)
            PASS_A:  result_o = op_a;
            OR_AB:   result_o = op_a | op_b;
            AND_AB:  result_o = op_a & op_b;
            OR_ALL:  result_o = or_chain[NUM_OPS-1];
            PASS_C:  result_o = op_c;
            SET:     result_o = '1;
            default: result_o = '0;
        endcase
    end

    assign tag_en_o = (mode != CLEAR) && (mode_i != TAG_MODE_WIDTH'(7));

endmodule

// File: rtl/riscv_ex_tag_pipe.sv
// EX-stage DIFT tag pipe: one-entry EX/WB tag slot with handshake, sticky PC tag,
// and a stalling tag-violation trap with a saturating violation counter.
module riscv_ex_tag_pipe
    import riscv_tag_pkg::*;
#(
    parameter int TAG_WIDTH = 1,
    parameter int NUM_OPS   = 3,
    parameter int CNT_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [TAG_MODE_WIDTH-1:0]     mode_i,
    input  logic [NUM_OPS*TAG_WIDTH-1:0]  op_tag_i,
    input  logic                          rf_we_i,
    input  logic                          data_we_i,
    input  logic                          branch_i,
    input  logic                          taken_i,
    input  logic [TAG_WIDTH-1:0]          check_mask_i,
    output logic                          wb_valid_o,
    input  logic                          wb_ready_i,
    output logic [TAG_WIDTH-1:0]          wb_tag_o,
    output logic                          wb_rf_we_o,
    output logic                          wb_data_we_o,
    output logic [TAG_WIDTH-1:0]          pc_tag_o,
    input  logic                          pc_tag_clr_i,
    output logic                          trap_req_o,
    input  logic                          trap_ack_i,
    output logic [CNT_WIDTH-1:0]          viol_cnt_o,
    input  logic                          viol_cnt_clr_i
);

    logic [TAG_WIDTH-1:0] policy_tag;
    logic                 tag_en;
    logic [TAG_WIDTH-1:0] op_c;
    logic [TAG_WIDTH-1:0] tgt_tag;
    logic                 acc;
    logic                 slot_load;
    logic                 ctrl_taken;
    logic                 violation;

    logic                 wb_valid_q,   wb_valid_d;
    logic [TAG_WIDTH-1:0] wb_tag_q,     wb_tag_d;
    logic                 wb_rf_we_q,   wb_rf_we_d;
    logic                 wb_data_we_q, wb_data_we_d;
    logic [TAG_WIDTH-1:0] pc_tag_q,     pc_tag_d;
    logic [CNT_WIDTH-1:0] viol_cnt_q,   viol_cnt_d;
    tag_fsm_e             state_q,      state_d;

    riscv_tag_policy #(
        .TAG_WIDTH (TAG_WIDTH),
        .NUM_OPS   (NUM_OPS)
    ) u_policy (
        .mode_i   (mode_i),
        .op_tag_i (op_tag_i),
        .result_o (policy_tag),
        .tag_en_o (tag_en)
    );

    assign op_c       = op_tag_i[(NUM_OPS-1)*TAG_WIDTH +: TAG_WIDTH];
    assign tgt_tag    = (op_c != '0) ? op_c : policy_tag;
    assign ready_o    = (state_q == IDLE) && (!wb_valid_q || wb_ready_i);
    assign acc        = valid_i && ready_o;
    assign slot_load  = acc && !branch_i;
    assign ctrl_taken = acc && branch_i && taken_i;
    assign violation  = ctrl_taken && ((tgt_tag & check_mask_i) != '0);

    always_comb begin
        wb_valid_d   = wb_valid_q;
        wb_tag_d     = wb_tag_q;
        wb_rf_we_d   = wb_rf_we_q;
        wb_data_we_d = wb_data_we_q;
        pc_tag_d     = pc_tag_q;
        viol_cnt_d   = viol_cnt_q;
        state_d      = state_q;

        // A consumed slot is refilled in the same cycle when a new result arrives.
        if (slot_load) begin
            wb_valid_d   = 1'b1;
            wb_tag_d     = policy_tag;
            wb_rf_we_d   = rf_we_i && tag_en;
            wb_data_we_d = data_we_i && tag_en;
        end else if (wb_ready_i) begin
            wb_valid_d   = 1'b0;
        end

        if (pc_tag_clr_i) begin
            pc_tag_d = '0;
        end else if (ctrl_taken) begin
            pc_tag_d = pc_tag_q | tgt_tag;
        end

        if (viol_cnt_clr_i) begin
            viol_cnt_d = '0;
        end else if (violation && (viol_cnt_q != '1)) begin
            viol_cnt_d = viol_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE:    if (violation)  state_d = PEND;
            PEND:    if (trap_ack_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q   <= 1'b0;
            wb_tag_q     <= '0;
            wb_rf_we_q   <= 1'b0;
            wb_data_we_q <= 1'b0;
            pc_tag_q     <= '0;
            viol_cnt_q   <= '0;
            state_q      <= IDLE;
        end else begin
            wb_valid_q   <= wb_valid_d;
            wb_tag_q     <= wb_tag_d;
            wb_rf_we_q   <= wb_rf_we_d;
            wb_data_we_q <= wb_data_we_d;
            pc_tag_q     <= pc_tag_d;
            viol_cnt_q   <= viol_cnt_d;
            state_q      <= state_d;
        end
    end

    assign wb_valid_o   = wb_valid_q;
    assign wb_tag_o     = wb_tag_q;
    assign wb_rf_we_o   = wb_rf_we_q;
    assign wb_data_we_o = wb_data_we_q;
    assign pc_tag_o     = pc_tag_q;
    assign trap_req_o   = (state_q == PEND);
    assign viol_cnt_o   = viol_cnt_q;

endmodule

// File: tb/tb_riscv_ex_tag_pipe.sv
// Directed bench for riscv_ex_tag_pipe: a behavioural model compared every cycle,
// plus hand-computed literal expectations at key points.
module tb_riscv_ex_tag_pipe;

    localparam int TW = 2;
    localparam int NO = 3;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid = 1'b0;
    logic          ready;
    logic [2:0]    mode = 3'd0;
    logic [NO*TW-1:0] ops = '0;
    logic          rf_we = 1'b0;
    logic          data_we = 1'b0;
    logic          branch = 1'b0;
    logic          taken = 1'b0;
    logic [TW-1:0] mask = '0;
    logic          wb_valid;
    logic          wb_ready = 1'b1;
    logic [TW-1:0] wb_tag;
    logic          wb_rf_we;
    logic          wb_data_we;
    logic [TW-1:0] pc_tag;
    logic          pc_clr = 1'b0;
    logic          trap;
    logic          ack = 1'b0;
    logic [CW-1:0] cnt;
    logic          cnt_clr = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    riscv_ex_tag_pipe #(
        .TAG_WIDTH (TW),
        .NUM_OPS   (NO),
        .CNT_WIDTH (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_i        (valid),
        .ready_o        (ready),
        .mode_i         (mode),
        .op_tag_i       (ops),
        .rf_we_i        (rf_we),
        .data_we_i      (data_we),
        .branch_i       (branch),
        .taken_i        (taken),
        .check_mask_i   (mask),
        .wb_valid_o     (wb_valid),
        .wb_ready_i     (wb_ready),
        .wb_tag_o       (wb_tag),
        .wb_rf_we_o     (wb_rf_we),
        .wb_data_we_o   (wb_data_we),
        .pc_tag_o       (pc_tag),
        .pc_tag_clr_i   (pc_clr),
        .trap_req_o     (trap),
        .trap_ack_i     (ack),
        .viol_cnt_o     (cnt),
        .viol_cnt_clr_i (cnt_clr)
    );

    // ---------------- behavioural model ----------------
    logic          m_wbv, m_rf, m_dw, m_trap;
    logic [TW-1:0] m_tag, m_pc;
    int            m_cnt;

    function automatic logic [TW-1:0] pol(input logic [2:0] md, input logic [NO*TW-1:0] o);
        logic [TW-1:0] a, b, c;
        a = o[1:0];
        b = o[3:2];
        c = o[5:4];
        case (md)
            3'd0:    return a;
            3'd1:    return a | b;
            3'd2:    return a & b;
            3'd3:    return a | b | c;
            3'd4:    return c;
            3'd6:    return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic m_ready_f(input logic trp, input logic wbv, input logic wr);
        return !trp && (!wbv || wr);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wbv <= 1'b0; m_rf <= 1'b0; m_dw <= 1'b0; m_trap <= 1'b0;
            m_tag <= '0; m_pc <= '0; m_cnt <= 0;
        end else begin
            logic acc_m, en_m, viol_m;
            logic [TW-1:0] res_m, tgt_m;
            acc_m  = valid && m_ready_f(m_trap, m_wbv, wb_ready);
            en_m   = !(mode == 3'd5 || mode == 3'd7);
            res_m  = pol(mode, ops);
            tgt_m  = (ops[5:4] != 2'b00) ? ops[5:4] : res_m;
            viol_m = acc_m && branch && taken && ((tgt_m & mask) != 2'b00);
            if (acc_m && !branch) begin
                m_wbv <= 1'b1; m_tag <= res_m;
                m_rf  <= rf_we && en_m; m_dw <= data_we && en_m;
            end else if (wb_ready) begin
                m_wbv <= 1'b0;
            end
            if (pc_clr) m_pc <= '0;
            else if (acc_m && branch && taken) m_pc <= m_pc | tgt_m;
            if (m_trap) begin
                if (ack) m_trap <= 1'b0;
            end else if (viol_m) begin
                m_trap <= 1'b1;
            end
            if (cnt_clr) m_cnt <= 0;
            else if (viol_m && m_cnt < (1 << CW) - 1) m_cnt <= m_cnt + 1;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("ready",      32'(ready),      32'(m_ready_f(m_trap, m_wbv, wb_ready)));
        check("wb_valid",   32'(wb_valid),   32'(m_wbv));
        check("wb_tag",     32'(wb_tag),     32'(m_tag));
        check("wb_rf_we",   32'(wb_rf_we),   32'(m_rf));
        check("wb_data_we", 32'(wb_data_we), 32'(m_dw));
        check("pc_tag",     32'(pc_tag),     32'(m_pc));
        check("trap_req",   32'(trap),       32'(m_trap));
        check("viol_cnt",   32'(cnt),        32'(m_cnt));
        $display("cycle t=%0t valid=%0d mode=%0d ops=%b br=%0d tk=%0d -> wbv=%0d tag=%b pc=%b trap=%0d cnt=%0d rdy=%0d",
                 $time, valid, mode, ops, branch, taken, wb_valid, wb_tag, pc_tag, trap, cnt, ready);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset
        tick(); tick();
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_trap",     32'(trap),     32'd0);
        check("rst_cnt",      32'(cnt),      32'd0);
        check("rst_ready",    32'(ready),    32'd1);
        rst_n = 1'b1;
        tick();

        // OR_AB: A=01, B=10
        valid = 1; mode = 3'd1; ops = 6'b00_10_01; rf_we = 1; wb_ready = 1;
        tick();
        check("orab_tag",   32'(wb_tag),   32'd3);
        check("orab_rf_we", 32'(wb_rf_we), 32'd1);
        check("orab_valid", 32'(wb_valid), 32'd1);

        // CLEAR, then reserved code 7
        mode = 3'd5; ops = 6'b00_11_11;
        tick();
        check("clear_tag",   32'(wb_tag),   32'd0);
        check("clear_rf_we", 32'(wb_rf_we), 32'd0);
        mode = 3'd7;
        tick();
        check("rsv7_tag",   32'(wb_tag),   32'd0);
        check("rsv7_rf_we", 32'(wb_rf_we), 32'd0);

        // SET replaces the full slot, then back-pressure holds it
        mode = 3'd6; data_we = 1; rf_we = 0;
        tick();
        check("set_tag", 32'(wb_tag), 32'd3);
        check("set_dwe", 32'(wb_data_we), 32'd1);
        valid = 0; wb_ready = 0; data_we = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_tag",   32'(wb_tag),   32'd3);
            check("hold_ready", 32'(ready),    32'd0);
            check("hold_valid", 32'(wb_valid), 32'd1);
        end
        wb_ready = 1;
        tick();
        check("release_valid", 32'(wb_valid), 32'd0);

        // Back-to-back accepts
        valid = 1; mode = 3'd0; ops = 6'b00_00_01;
        tick();
        mode = 3'd3; ops = 6'b01_00_00;
        tick();
        check("orall_tag", 32'(wb_tag), 32'd1);

        // Taken branch, no check bits: PC tag set, slot not loaded
        branch = 1; taken = 1; mode = 3'd0; ops = 6'b00_00_10; mask = 2'b00;
        tick();
        check("br_pc",   32'(pc_tag), 32'd2);
        check("br_trap", 32'(trap),   32'd0);
        check("br_slot", 32'(wb_tag), 32'd1);
        pc_clr = 1; ops = 6'b00_00_01;
        tick();
        check("pcclr_pc", 32'(pc_tag), 32'd0);
        pc_clr = 0;

        // Not-taken branch leaves PC tag alone
        taken = 0; ops = 6'b01_00_00;
        tick();
        check("nt_pc", 32'(pc_tag), 32'd0);

        // Violation: C=01 with mask 01
        taken = 1; ops = 6'b01_00_00; mask = 2'b01;
        tick();
        check("viol_trap",  32'(trap),  32'd1);
        check("viol_cnt",   32'(cnt),   32'd1);
        check("viol_ready", 32'(ready), 32'd0);
        valid = 0;
        tick(); tick();
        check("pend_trap", 32'(trap), 32'd1);
        ack = 1;
        tick();
        check("ack_trap",  32'(trap),  32'd0);
        check("ack_ready", 32'(ready), 32'd1);
        tick();   // ack while idle is ignored
        ack = 0;

        // Three more violations, each acked in the first pending cycle
        for (int i = 0; i < 3; i++) begin
            valid = 1;
            tick();
            valid = 0; ack = 1;
            tick();
            ack = 0;
        end
        check("sat_cnt", 32'(cnt), 32'd3);

        // Load a nonzero slot, then violation with a same-cycle counter clear
        branch = 0; taken = 0; mode = 3'd6; valid = 1;
        tick();
        branch = 1; taken = 1; mode = 3'd0; cnt_clr = 1;
        tick();
        check("cntclr_cnt",  32'(cnt),  32'd0);
        check("cntclr_trap", 32'(trap), 32'd1);
        valid = 0; cnt_clr = 0; branch = 0; taken = 0;

        // Asynchronous reset while pending
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        check("arst_trap",   32'(trap),     32'd0);
        check("arst_tag",    32'(wb_tag),   32'd0);
        check("arst_pc",     32'(pc_tag),   32'd0);
        check("arst_cnt",    32'(cnt),      32'd0);
        check("arst_valid",  32'(wb_valid), 32'd0);
        check("arst_ready",  32'(ready),    32'd1);
        tick();
        rst_n = 1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
